// File: rtl/inv_mixcolumns_seq.sv
// rtl/inv_mixcolumns_seq.sv - sequential AES InvMixColumns, one column per cycle
module inv_mixcolumns_seq (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t       state;
  state_t       state_nxt;
  logic [1:0]   col_cnt;
  logic [127:0] in_reg;
  logic [127:0] res_reg;
  logic [31:0]  col_in;
  logic [31:0]  col_out;

  // GF(2^8) multiply by x, reduced by x^8+x^4+x^3+x+1
  function automatic logic [7:0] xtime(input logic [7:0] b);
    xtime = {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Products of one byte by the four InvMixColumns constants, packed {09, 0b, 0d, 0e}
  function automatic logic [31:0] inv_terms(input logic [7:0] a);
    logic [7:0] x2, x4, x8;
    x2 = xtime(a);
    x4 = xtime(x2);
    x8 = xtime(x4);
    inv_terms = {x8 ^ a, x8 ^ x2 ^ a, x8 ^ x4 ^ a, x8 ^ x4 ^ x2};
  endfunction

  // Column select: col_cnt 0 picks the top column [127:96], 3 picks [31:0]
  always_comb begin
    col_in = in_reg[31:0];
    case (col_cnt)
      2'd0:    col_in = in_reg[127:96];
      2'd1:    col_in = in_reg[95:64];
      2'd2:    col_in = in_reg[63:32];
      default: col_in = in_reg[31:0];
    endcase
  end

  // Shared single-column multiply network
  always_comb begin
    logic [31:0] t0, t1, t2, t3;
    t0 = inv_terms(col_in[31:24]);
    t1 = inv_terms(col_in[23:16]);
    t2 = inv_terms(col_in[15:8]);
    t3 = inv_terms(col_in[7:0]);
    // byte lanes of tN: [31:24]=09, [23:16]=0b, [15:8]=0d, [7:0]=0e
    col_out[31:24] = t0[7:0]   ^ t1[23:16] ^ t2[15:8]  ^ t3[31:24];
    col_out[23:16] = t0[31:24] ^ t1[7:0]   ^ t2[23:16] ^ t3[15:8];
    col_out[15:8]  = t0[15:8]  ^ t1[31:24] ^ t2[7:0]   ^ t3[23:16];
    col_out[7:0]   = t0[23:16] ^ t1[15:8]  ^ t2[31:24] ^ t3[7:0];
  end

  // Next-state logic and handshake outputs, decoded from state only
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = BUSY;
      end
      BUSY: begin
        if (col_cnt == 2'd3) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Input capture, column counter and result slices; reset discards any in-flight result
  always_ff @(posedge clk) begin
    if (rst) begin
      col_cnt <= 2'd0;
      in_reg  <= 128'd0;
      res_reg <= 128'd0;
    end else begin
      if (state == IDLE && in_valid) begin
        in_reg  <= in_data;
        col_cnt <= 2'd0;
      end
      if (state == BUSY) begin
        col_cnt <= col_cnt + 2'd1;
        case (col_cnt)
          2'd0:    res_reg[127:96] <= col_out;
          2'd1:    res_reg[95:64]  <= col_out;
          2'd2:    res_reg[63:32]  <= col_out;
          default: res_reg[31:0]   <= col_out;
        endcase
      end
    end
  end

  assign out_data = res_reg;

endmodule

// File: tb/tb_inv_mixcolumns_seq.sv
// tb/tb_inv_mixcolumns_seq.sv - scoreboard bench for inv_mixcolumns_seq
module tb_inv_mixcolumns_seq;

  localparam int ACCEPT_GAP = 6;
  localparam int LATENCY    = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;

  inv_mixcolumns_seq dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  always #5 clk = ~clk;

  int           n_checks = 0;
  int           n_fail   = 0;
  int           cyc      = 0;
  int           last_acc = 0;
  bit           have_last = 0;
  bit           gap_en   = 0;
  bit           accepted = 0;
  string        phase    = "init";
  logic [127:0] exp_next = '0;
  logic [127:0] exp_q[$];
  logic         s_in_ready  = 1'b0;
  logic         s_out_valid = 1'b0;
  logic [127:0] s_out_data  = '0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa, bb;
    p = 8'h00; aa = a; bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = aa[7] ? ({aa[6:0], 1'b0} ^ 8'h1b) : {aa[6:0], 1'b0};
      bb = bb >> 1;
    end
    return p;
  endfunction

  function automatic logic [127:0] mix(input logic [127:0] s, input logic [7:0] c0,
                                       input logic [7:0] c1, input logic [7:0] c2,
                                       input logic [7:0] c3);
    logic [127:0] r;
    logic [7:0]   a [4];
    logic [7:0]   k [4];
    k[0] = c0; k[1] = c1; k[2] = c2; k[3] = c3;
    for (int c = 0; c < 4; c++) begin
      for (int j = 0; j < 4; j++) a[j] = s[32*c + 24 - 8*j +: 8];
      for (int row = 0; row < 4; row++) begin
        logic [7:0] acc;
        acc = 8'h00;
        for (int j = 0; j < 4; j++) acc = acc ^ gmul(k[(j - row + 4) % 4], a[j]);
        r[32*c + 24 - 8*row +: 8] = acc;
      end
    end
    return r;
  endfunction

  function automatic logic [127:0] inv_mix(input logic [127:0] s);
    return mix(s, 8'h0e, 8'h0b, 8'h0d, 8'h09);
  endfunction

  function automatic logic [127:0] fwd_mix(input logic [127:0] s);
    return mix(s, 8'h02, 8'h03, 8'h01, 8'h01);
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic cycle();
    logic rose;
    @(posedge clk);
    #1;
    cyc++;
    if (rst) begin
      exp_q.delete();
    end else begin
      if (s_in_ready && in_valid) begin
        exp_q.push_back(exp_next);
        accepted = 1'b1;
        if (gap_en && have_last) check("accept_gap", cyc - last_acc, ACCEPT_GAP);
        last_acc  = cyc;
        have_last = 1'b1;
      end
      if (s_out_valid && out_ready) begin
        check("out_expected", 128'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) check({"out_", phase}, s_out_data, exp_q.pop_front());
      end
    end
    rose        = out_valid && !s_out_valid;
    s_in_ready  = in_ready;
    s_out_valid = out_valid;
    s_out_data  = out_data;
    if (rose && !rst) check("latency", cyc - last_acc, LATENCY);
  endtask

  task automatic send(input logic [127:0] d, input logic [127:0] e);
    int n;
    in_data  = d;
    exp_next = e;
    in_valid = 1'b1;
    accepted = 1'b0;
    n = 0;
    while (!accepted && n < 20) begin
      cycle();
      n++;
    end
    in_valid = 1'b0;
    check("accept_wait", accepted, 1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      cycle();
      n++;
    end
    check("drain", exp_q.size(), 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] a, b, x, r;
    int n;

    // power-up reset with in_valid asserted
    rst = 1'b1; in_valid = 1'b1; in_data = rand128(); out_ready = 1'b1;
    repeat (3) begin
      cycle();
      check("rst_out_valid", out_valid, 0);
      check("rst_out_data", out_data, 0);
      check("rst_in_ready", in_ready, 1);
    end
    rst = 1'b0; in_valid = 1'b0;
    cycle();
    check("rst_no_capture", exp_q.size(), 0);
    check("rst_idle_out_valid", out_valid, 0);

    phase = "fips";
    send(128'h8e4da1bc_9fdc589d_01010101_d5d5d7d6, 128'hdb135345_f20a225c_01010101_d4d4d4d5);
    drain();

    phase = "fixed";
    send(128'hc6c6c6c6_01010101_00000000_ffffffff, 128'hc6c6c6c6_01010101_00000000_ffffffff);
    drain();
    send(128'h0, 128'h0);
    drain();

    // back-to-back round trip through the forward transform
    phase = "roundtrip";
    gap_en = 1'b1; have_last = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      r = rand128();
      in_data  = fwd_mix(r);
      exp_next = r;
      accepted = 1'b0;
      n = 0;
      while (!accepted && n < 20) begin
        cycle();
        n++;
      end
      check("rt_accept_wait", accepted, 1);
    end
    in_valid = 1'b0;
    gap_en = 1'b0;
    drain();

    // backpressure: hold out_ready low with a second state waiting
    phase = "bp";
    out_ready = 1'b0;
    a = rand128();
    send(a, inv_mix(a));
    n = 0;
    while (!out_valid && n < 20) begin
      cycle();
      n++;
    end
    check("bp_valid_wait", out_valid, 1);
    b = rand128();
    in_valid = 1'b1; in_data = b; exp_next = inv_mix(b); accepted = 1'b0;
    repeat (7) begin
      cycle();
      check("bp_hold_valid", out_valid, 1);
      check("bp_hold_data", out_data, inv_mix(a));
      check("bp_in_ready", in_ready, 0);
    end
    check("bp_no_capture", accepted, 0);
    out_ready = 1'b1;
    cycle();
    check("bp_release_in_ready", in_ready, 1);
    check("bp_release_out_valid", out_valid, 0);
    check("bp_popped_a", exp_q.size(), 0);
    cycle();
    check("bp_accept_b", accepted, 1);
    in_valid = 1'b0;
    drain();

    // reset two edges after an acceptance
    phase = "rstmid";
    x = rand128();
    send(x, inv_mix(x));
    cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    check("rm_out_data", out_data, 0);
    check("rm_in_ready", in_ready, 1);
    check("rm_out_valid", out_valid, 0);
    repeat (8) begin
      cycle();
      check("rm_no_valid", out_valid, 0);
    end
    send({4{32'h01010101}}, {4{32'h01010101}});
    drain();

    check("final_queue", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
